nib_track_flush: RTL
====================

Name: nib_track_flush

Overview:
- Write-back stage for the Disk II NIB track buffer. It sits between the drive's track RAM and the SD block interface, downstream of the track RAM the drive writes into.
- Tracks whether the resident track has been modified. When it has, the block writes all SECTORS 512-byte blocks of that track back to the image before the track loader may fetch a new track.
- It also presents the loader with a debounced load_track that only advances once any pending flush has completed.

Parameters:
- SECTORS, 13, 512-byte SD blocks per NIB track (6656 bytes).
- IDLE_CYCLES, 14318180, clk_sys cycles without track writes before an idle flush (used only with TRACK_IDLE_FLUSH_EN).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- track  in  6  head track requested by the drive.
- track_we  in  1  drive wrote a byte into track RAM this cycle.
- img_mounted  in  1  one-cycle pulse, new image mounted.
- img_readonly  in  1  image is write-protected; never flush.
- img_size_nz  in  1  an image is present (img_size != 0).
- load_track  out  6  track the loader must fetch and which is resident in RAM.
- busy  out  1  flush in progress; loader must not start while high.
- cpu_wait  out  1  stall request to CPU during flush.
- sd_lba  out  32  SD block address.
- sd_wr  out  1  SD write request.
- sd_ack  in  1  SD sector handshake from HPS.
- sd_buff_addr  in  9  byte index within the current sector.
- ram_rd_addr  out  13  track RAM read address = {sec, sd_buff_addr}.
- ram_rd_data  in  8  track RAM read data.
- sd_buff_din  out  8  = ram_rd_data (combinational pass-through).

Behaviour:
- Reset values: load_track=track, busy=0, cpu_wait=0, sd_wr=0, sd_lba=0, sec=0, dirty=0, state=IDLE.
- dirty:
  - Set on track_we when img_readonly=0 and img_size_nz=1.
  - Cleared on the cycle a flush enters START.
  - A track_we during a flush sets dirty_again, which is copied into dirty when the flush returns to IDLE.
- IDLE:
  - If track != load_track and dirty=0: load_track<=track next cycle, no SD traffic.
  - If track != load_track and dirty=1: go to START. busy and cpu_wait rise on that same edge.
- START (1 cycle):
  - sd_lba<=SECTORS*load_track, 10-bit product zero-extended.
  - sec<=0, sd_wr<=1, go to XFER.
- XFER:
  - On sd_ack rising edge: sd_lba<=sd_lba+1. If sec>=SECTORS-1, sd_wr<=0.
  - On sd_ack falling edge: sec<=sec+1. If sd_wr=0, go to DONE.
  - Edges are detected against a 1-cycle registered copy of sd_ack.
- DONE (1 cycle):
  - load_track<=track (the latest value), busy<=0, cpu_wait<=0, go to IDLE.
  - If the new track still differs after a re-dirty, the next flush starts normally from IDLE.
- img_mounted:
  - In IDLE: clear dirty and dirty_again, load_track<=track.
  - In XFER: set abort. sd_wr<=0 at the next sd_ack rising edge (or immediately if sd_ack is already high). Finish the current sector's falling edge, then go to DONE with dirty and dirty_again cleared. Never leave sd_wr high without an ack cycle completing.
- img_readonly=1 or img_size_nz=0: track_we is ignored; a track change never flushes.
- Simultaneous track_we and track change in IDLE: the write counts toward dirty, so a flush occurs.
- Reset mid-flush: all state returns to reset values on the next edge. The partially written image is accepted.
- ram_rd_addr = {sec[3:0], sd_buff_addr}; sd_buff_din follows ram_rd_data with no added register.

Optional Feature:
- Macro TRACK_IDLE_FLUSH_EN.
- Defined:
  - A 24-bit counter reloads to IDLE_CYCLES on every track_we and decrements while dirty=1 in IDLE.
  - At 0, a flush of load_track starts without a track change; load_track is unchanged in DONE.
  - The counter holds 0 until the next write.
- Undefined: the counter is absent; flushes occur only on a track change.

Test Plan:
- Clean track change: track 0->5 with no writes -> load_track=5 within 1 cycle, sd_wr never asserted, busy stays 0.
- Dirty flush: write at track 3, then track->4 -> busy=1. sd_lba=39..51 across 13 ack pulses. sd_wr drops at the 13th ack rise. load_track=4 one cycle after the 13th ack fall.
- Data path: model RAM with byte = sec^addr[7:0]. Sector 7, sd_buff_addr=0x1FF -> ram_rd_addr=0xFFF, sd_buff_din=0xF8.
- Read-only: img_readonly=1, track_we pulses, track 2->3 -> no sd_wr, load_track=3.
- Mount abort: img_mounted during sector 4 -> sector 4 completes, no sector 5 request, busy=0, dirty=0.
- Idle flush (macro on, IDLE_CYCLES=100): one write at track 9, no track change -> flush starts at cycle 101 with sd_lba=117; load_track stays 9.

Source files
------------

// File: rtl/nib_track_flush.sv
// Disk II NIB track write-back: flushes a modified track to the SD image before the loader moves on.
// Optional idle flush after a quiet period is enabled with `define TRACK_IDLE_FLUSH_EN.
//
// state | meaning
// IDLE  | track resident, tracking writes, waiting for a track change (or idle timeout)
// START | one cycle: latch first block address of load_track, raise sd_wr
// XFER  | one sector per sd_ack pulse until all SECTORS (or abort) are written
// DONE  | one cycle: release busy/cpu_wait, adopt the newest track
module nib_track_flush #(
  parameter int SECTORS     = 13,
  parameter int IDLE_CYCLES = 14318180
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        track_we,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  output logic [5:0]  load_track,
  output logic        busy,
  output logic        cpu_wait,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [12:0] ram_rd_addr,
  input  logic [7:0]  ram_rd_data,
  output logic [7:0]  sd_buff_din
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  localparam logic [9:0] SECTORS_W = 10'(SECTORS);
  localparam logic [3:0] LAST_SEC  = 4'(SECTORS - 1);

  state_t     state;
  logic       sd_ack_d;
  logic       dirty;
  logic       dirty_again;
  logic       abort;
  logic       keep_track;
  logic [3:0] sec;
  logic [9:0] lba_base;
  logic       we_ok;
  logic       ack_rise;
  logic       ack_fall;
  logic       track_chg;
  logic       idle_go;

  assign we_ok       = track_we & ~img_readonly & img_size_nz;
  assign ack_rise    = sd_ack & ~sd_ack_d;
  assign ack_fall    = ~sd_ack & sd_ack_d;
  assign track_chg   = (track != load_track);
  assign lba_base    = SECTORS_W * {4'd0, load_track};
  assign ram_rd_addr = {sec, sd_buff_addr};
  assign sd_buff_din = ram_rd_data;

`ifdef TRACK_IDLE_FLUSH_EN
  logic [23:0] idle_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset)
      idle_cnt <= '0;
    else if (track_we)
      idle_cnt <= 24'(IDLE_CYCLES);
    else if (state == IDLE && dirty && idle_cnt != 24'd0)
      idle_cnt <= idle_cnt - 24'd1;
  end

  assign idle_go = dirty && (idle_cnt == 24'd0);
`else
  assign idle_go = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      load_track  <= track;
      busy        <= 1'b0;
      cpu_wait    <= 1'b0;
      sd_wr       <= 1'b0;
      sd_lba      <= '0;
      sec         <= '0;
      dirty       <= 1'b0;
      dirty_again <= 1'b0;
      abort       <= 1'b0;
      keep_track  <= 1'b0;
      sd_ack_d    <= 1'b0;
    end else begin
      sd_ack_d <= sd_ack;
      case (state)
        IDLE: begin
          if (img_mounted) begin
            dirty       <= 1'b0;
            dirty_again <= 1'b0;
            load_track  <= track;
          end else if (track_chg && !(dirty || we_ok)) begin
            load_track <= track;
          end else if (track_chg || idle_go) begin
            // a write landing on the change edge still belongs to the old track
            state      <= START;
            busy       <= 1'b1;
            cpu_wait   <= 1'b1;
            dirty      <= 1'b0;
            keep_track <= ~track_chg;
          end else if (we_ok) begin
            dirty <= 1'b1;
          end
        end
        START: begin
          sd_lba <= {22'd0, lba_base};
          sec    <= '0;
          sd_wr  <= 1'b1;
          state  <= XFER;
          if (we_ok)       dirty_again <= 1'b1;
          if (img_mounted) abort       <= 1'b1;
        end
        XFER: begin
          if (we_ok)       dirty_again <= 1'b1;
          if (img_mounted) abort       <= 1'b1;
          if (ack_rise) begin
            sd_lba <= sd_lba + 32'd1;
            if (sec >= LAST_SEC || abort || img_mounted) sd_wr <= 1'b0;
          end else if (img_mounted && sd_ack) begin
            sd_wr <= 1'b0;
          end
          if (ack_fall) begin
            sec <= sec + 4'd1;
            if (!sd_wr) state <= DONE;
          end
        end
        DONE: begin
          if (!keep_track) load_track <= track;
          busy        <= 1'b0;
          cpu_wait    <= 1'b0;
          dirty       <= (abort || img_mounted) ? 1'b0 : (dirty_again || we_ok);
          dirty_again <= 1'b0;
          abort       <= 1'b0;
          keep_track  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
